ring_monitor: RTL and testbench
===============================

Name: ring_monitor

Overview:
- Receive-side checker and decoder for a WIDTH-bit one-hot ring counter bus.
- Each sample is decoded to a binary index and checked for a legal one-hot value and correct left-rotation sequencing.
- Reports lock status and single-cycle error pulses, and keeps a saturating error count.
- Sits downstream of any ring-counter driven sequencer, e.g. as a phase monitor or safety checker.

Parameters:
- WIDTH, 4, ring width in bits (>=2).
- LOCK_CNT, 2, consecutive correct rotations required to declare lock (>=1).
- ERR_CNT_W, 8, width of the saturating error counter.

Ports:
- Clock  input  1  rising-edge clock.
- Reset  input  1  synchronous, active-high reset.
- Sample_valid  input  1  Ring_in is sampled on this edge.
- Ring_in  input  WIDTH  ring counter bus under observation.
- Index_out  output  clog2(WIDTH)  binary position of the hot bit.
- Index_valid  output  1  Index_out updated from a legal one-hot sample this cycle.
- Locked  output  1  sequence tracking established.
- Err_pulse  output  1  one-cycle pulse on any sequencing or encoding error while Locked.
- Err_count  output  ERR_CNT_W  saturating count of Err_pulse events.

Behaviour:
- Reset is synchronous and active-high, and dominates all inputs.
- Reset values: Index_out=0, Index_valid=0, Locked=0, Err_pulse=0, Err_count=0. Internal: prev=0, prev_ok=0, match_cnt=0, state=HUNT.
- All outputs are registered, with 1-cycle latency from the sampling edge.
- Legal rotation: next = {prev[WIDTH-2:0], prev[WIDTH-1]}, so the index increments by 1 mod WIDTH. Wrap-around from MSB to bit0 is legal.
- One-hot check: exactly one bit set. Values 0 and multi-hot are illegal.
- Sample_valid=0: no state change, Index_valid=0, Err_pulse=0, Index_out holds.
- Legal sample: Index_out takes the decoded index and Index_valid=1.
- Illegal sample: Index_valid=0 and Index_out holds.
- FSM state HUNT (Locked=0):
  - Illegal sample -> prev_ok=0, match_cnt=0.
  - Legal sample with prev_ok=0, or not equal to rotl(prev) -> prev=sample, prev_ok=1, match_cnt=0.
  - Legal sample equal to rotl(prev) -> prev=sample, match_cnt+1.
  - When match_cnt reaches LOCK_CNT -> LOCKED. Locked=1 from the following cycle.
  - No errors are flagged in HUNT.
- FSM state LOCKED (Locked=1):
  - Sample equal to rotl(prev) -> prev=sample, stay LOCKED.
  - Any other sample (illegal, or wrong position) -> Err_pulse=1 for one cycle, Err_count+1 saturating at 2^ERR_CNT_W-1, state=HUNT, Locked=0 next cycle.
  - On that error, if the sample is legal it reloads prev with prev_ok=1 and match_cnt=0; otherwise prev_ok=0.
- Simultaneous Reset and Sample_valid: Reset wins and the sample is discarded.
- Reset mid-lock returns to HUNT and clears Err_count.

Optional Feature:
- Macro: RING_MON_STALL_EN.
- Defined: a legal sample equal to prev is a stall. There is no progress and no error, match_cnt holds in HUNT, Locked holds in LOCKED, and Index_valid=1.
- Undefined: a repeated value is a mismatch. In HUNT it restarts match_cnt at 0; in LOCKED it is an error.

Decomposition:
- Package ring_pkg holds:
  - state enum {HUNT, LOCKED};
  - default WIDTH constant;
  - rotl function;
  - index-width helper (clog2).
- Sub-module onehot_to_bin is purely combinational. It takes Ring_in and produces the index and an is_onehot flag.
- The FSM, counters and output registers live in ring_monitor.

Test Plan:
- Reset, then samples 0001, 0010, 0100 on consecutive cycles -> Index_out 0, 1, 2 each one cycle later with Index_valid=1; Locked=1 the cycle after 0100.
- Locked, then samples 1000, 0001 -> wrap accepted; Index_out 3, 0; no Err_pulse.
- Locked at 0010, then sample 1000 -> Err_pulse=1 for one cycle, Err_count=1, Locked=0; then 0001, 0010 -> Locked=1 again.
- Locked, then samples 0000 and 0110 -> first produces Err_pulse and Err_count+1 with Index_valid=0; the second, in HUNT, produces no error.
- Force 260 errors with ERR_CNT_W=8 -> Err_count saturates at 255.
- Locked, sample 0100 repeated twice -> with RING_MON_STALL_EN, no error and Locked stays 1; without it, Err_pulse=1. Then assert Reset together with Sample_valid -> all outputs 0 next cycle.

Source files
------------

// File: rtl/ring_pkg.sv
// Shared types and helpers for the ring-counter monitor.
//   ring_state_e : tracking FSM states (HUNT, LOCKED)
//   DefWidth     : default ring width
//   MaxWidth     : widest ring the rotl helper supports
//   rotl()       : rotate-left by one within a w-bit field
//   idx_w()      : bits needed to hold a binary index into a w-bit ring
package ring_pkg;

    typedef enum logic {
        HUNT,
        LOCKED
    } ring_state_e;

    localparam int unsigned DefWidth = 4;
    localparam int unsigned MaxWidth = 64;

    // Rotate the low w bits of v left by one. Bits above w are cleared.
    function automatic logic [MaxWidth-1:0] rotl(input logic [MaxWidth-1:0] v,
                                                 input int unsigned w);
        logic [MaxWidth-1:0] mask;
        mask = {MaxWidth{1'b1}} >> (MaxWidth - w);
        return ((v << 1) | (v >> (w - 1))) & mask;
    endfunction

    function automatic int unsigned idx_w(input int unsigned w);
        return (w < 2) ? 1 : $clog2(w);
    endfunction

endpackage

// File: rtl/ring_monitor_if.sv
// Observation bus between a ring-counter sampler and the ring monitor.
//   master : drives Sample_valid / Ring_in, observes the monitor results
//   slave  : the monitor side (consumes samples, produces index/lock/error)
interface ring_monitor_if #(
    parameter int unsigned WIDTH     = ring_pkg::DefWidth,
    parameter int unsigned ERR_CNT_W = 8
) ();

    localparam int unsigned IdxW = ring_pkg::idx_w(WIDTH);

    logic                 Sample_valid;
    logic [WIDTH-1:0]     Ring_in;
    logic [IdxW-1:0]      Index_out;
    logic                 Index_valid;
    logic                 Locked;
    logic                 Err_pulse;
    logic [ERR_CNT_W-1:0] Err_count;

    modport master (
        output Sample_valid, Ring_in,
        input  Index_out, Index_valid, Locked, Err_pulse, Err_count
    );

    modport slave (
        input  Sample_valid, Ring_in,
        output Index_out, Index_valid, Locked, Err_pulse, Err_count
    );

endinterface

// File: rtl/onehot_to_bin.sv
// Combinational one-hot decoder.
//   ring_i      : sampled ring bus
//   index_o     : binary position of the set bit (meaningful only when one-hot)
//   is_onehot_o : exactly one bit of ring_i is set
module onehot_to_bin
    import ring_pkg::*;
#(
    parameter int unsigned WIDTH = DefWidth,
    localparam int unsigned IdxW = idx_w(WIDTH)
) (
    input  logic [WIDTH-1:0] ring_i,
    output logic [IdxW-1:0]  index_o,
    output logic             is_onehot_o
);

    always_comb begin
        index_o = '0;
        for (int unsigned i = 0; i < WIDTH; i++) begin
            if (ring_i[i]) begin
                index_o = index_o | IdxW'(i);
            end
        end
    end

    // Clearing the lowest set bit leaves zero only for a single-bit value.
    assign is_onehot_o = (ring_i != '0) && ((ring_i & (ring_i - WIDTH'(1))) == '0);

endmodule

// File: rtl/ring_monitor.sv
// Receive-side checker/decoder for a one-hot ring counter bus.
// Decodes each valid sample to a binary index, hunts for LOCK_CNT consecutive
// left rotations to declare lock, and while locked flags any bad sample with a
// one-cycle error pulse and a saturating error count. All outputs registered.
//   Clock : rising-edge clock
//   Reset : synchronous, active-high reset
//   bus   : ring_monitor_if slave (Sample_valid, Ring_in in; Index_out,
//           Index_valid, Locked, Err_pulse, Err_count out)
// Build option: define RING_MON_STALL_EN to treat a repeated legal sample as a
// stall (no progress, no error) instead of a mismatch.
module ring_monitor
    import ring_pkg::*;
#(
    parameter int unsigned WIDTH     = DefWidth,
    parameter int unsigned LOCK_CNT  = 2,
    parameter int unsigned ERR_CNT_W = 8
) (
    input logic           Clock,
    input logic           Reset,
    ring_monitor_if.slave bus
);

    localparam int unsigned IdxW = idx_w(WIDTH);
    localparam int unsigned CntW = $clog2(LOCK_CNT + 1);

`ifdef RING_MON_STALL_EN
    localparam bit StallEn = 1'b1;
`else
    localparam bit StallEn = 1'b0;
`endif

    ring_state_e          state_q, state_d;
    logic [WIDTH-1:0]     prev_q, prev_d;
    logic                 prev_ok_q, prev_ok_d;
    logic [CntW-1:0]      match_q, match_d;
    logic [IdxW-1:0]      index_q, index_d;
    logic                 index_valid_q, index_valid_d;
    logic                 err_pulse_q, err_pulse_d;
    logic [ERR_CNT_W-1:0] err_cnt_q, err_cnt_d;

    logic [WIDTH-1:0] sample;
    logic [WIDTH-1:0] expected;
    logic [IdxW-1:0]  dec_index;
    logic             is_onehot;
    logic             is_step;
    logic             is_stall;

    assign sample = bus.Ring_in;

    onehot_to_bin #(
        .WIDTH(WIDTH)
    ) u_dec (
        .ring_i      (sample),
        .index_o     (dec_index),
        .is_onehot_o (is_onehot)
    );

    assign expected = WIDTH'(rotl(MaxWidth'(prev_q), WIDTH));

    // prev_q is only trustworthy when prev_ok_q; it is always set while locked.
    assign is_step  = is_onehot && prev_ok_q && (sample == expected);
    assign is_stall = StallEn && is_onehot && prev_ok_q && (sample == prev_q);

    always_comb begin
        state_d       = state_q;
        prev_d        = prev_q;
        prev_ok_d     = prev_ok_q;
        match_d       = match_q;
        index_d       = index_q;
        index_valid_d = 1'b0;
        err_pulse_d   = 1'b0;
        err_cnt_d     = err_cnt_q;

        if (bus.Sample_valid) begin
            if (is_onehot) begin
                index_d       = dec_index;
                index_valid_d = 1'b1;
            end

            unique case (state_q)
                HUNT: begin
                    if (!is_onehot) begin
                        prev_ok_d = 1'b0;
                        match_d   = '0;
                    end else if (is_stall) begin
                        match_d = match_q;
                    end else if (is_step) begin
                        prev_d  = sample;
                        match_d = match_q + CntW'(1);
                        if (match_d == CntW'(LOCK_CNT)) begin
                            state_d = LOCKED;
                        end
                    end else begin
                        prev_d    = sample;
                        prev_ok_d = 1'b1;
                        match_d   = '0;
                    end
                end
                LOCKED: begin
                    if (is_step) begin
                        prev_d = sample;
                    end else if (is_stall) begin
                        prev_d = prev_q;
                    end else begin
                        err_pulse_d = 1'b1;
                        if (err_cnt_q != '1) begin
                            err_cnt_d = err_cnt_q + ERR_CNT_W'(1);
                        end
                        state_d = HUNT;
                        match_d = '0;
                        // A legal but misplaced sample becomes the new hunt origin.
                        if (is_onehot) begin
                            prev_d    = sample;
                            prev_ok_d = 1'b1;
                        end else begin
                            prev_ok_d = 1'b0;
                        end
                    end
                end
            endcase
        end
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state_q       <= HUNT;
            prev_q        <= '0;
            prev_ok_q     <= 1'b0;
            match_q       <= '0;
            index_q       <= '0;
            index_valid_q <= 1'b0;
            err_pulse_q   <= 1'b0;
            err_cnt_q     <= '0;
        end else begin
            state_q       <= state_d;
            prev_q        <= prev_d;
            prev_ok_q     <= prev_ok_d;
            match_q       <= match_d;
            index_q       <= index_d;
            index_valid_q <= index_valid_d;
            err_pulse_q   <= err_pulse_d;
            err_cnt_q     <= err_cnt_d;
        end
    end

    assign bus.Index_out   = index_q;
    assign bus.Index_valid = index_valid_q;
    assign bus.Locked      = (state_q == LOCKED);
    assign bus.Err_pulse   = err_pulse_q;
    assign bus.Err_count   = err_cnt_q;

endmodule

// File: tb/tb_ring_monitor.sv
// Self-checking bench for ring_monitor: directed vector table, randomized
// traffic against an index-arithmetic reference model, and error saturation.
module tb_ring_monitor;

    localparam int unsigned W       = 4;
    localparam int unsigned LockCnt = 2;
    localparam int unsigned ErrW    = 8;
    localparam int          ErrMax  = 255;

`ifdef RING_MON_STALL_EN
    localparam bit StallEn = 1'b1;
`else
    localparam bit StallEn = 1'b0;
`endif

    logic Clock = 1'b0;
    logic Reset = 1'b1;

    ring_monitor_if #(.WIDTH(W), .ERR_CNT_W(ErrW)) bus ();

    ring_monitor #(
        .WIDTH     (W),
        .LOCK_CNT  (LockCnt),
        .ERR_CNT_W (ErrW)
    ) dut (
        .Clock (Clock),
        .Reset (Reset),
        .bus   (bus)
    );

    always #5 Clock = ~Clock;

    int tests = 0;
    int fails = 0;

    // Reference model state, expressed as ring positions rather than bit vectors.
    int m_prev;
    bit m_prev_ok;
    int m_match;
    bit m_locked;
    int m_cnt;
    int m_idx;
    bit m_iv;
    bit m_err;

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    function automatic void model_reset();
        m_prev = 0; m_prev_ok = 0; m_match = 0; m_locked = 0;
        m_cnt = 0; m_idx = 0; m_iv = 0; m_err = 0;
    endfunction

    function automatic void model_step(input bit rst, input bit v, input logic [W-1:0] ring);
        bit legal;
        int pos;
        bit progress;
        bit stall;
        if (rst) begin
            model_reset();
            return;
        end
        m_iv  = 0;
        m_err = 0;
        if (!v) return;
        legal = ($countones(ring) == 1);
        pos = 0;
        for (int i = 0; i < int'(W); i++) if (ring[i]) pos = i;
        if (legal) begin
            m_idx = pos;
            m_iv  = 1;
        end
        progress = legal && m_prev_ok && (pos == (m_prev + 1) % int'(W));
        stall    = StallEn && legal && m_prev_ok && (pos == m_prev);
        if (m_locked) begin
            if (progress) begin
                m_prev = pos;
            end else if (!stall) begin
                m_err    = 1;
                m_cnt    = (m_cnt < ErrMax) ? m_cnt + 1 : ErrMax;
                m_locked = 0;
                m_match  = 0;
                m_prev_ok = legal;
                if (legal) m_prev = pos;
            end
        end else begin
            if (!legal) begin
                m_prev_ok = 0;
                m_match   = 0;
            end else if (!stall) begin
                if (progress) begin
                    m_prev  = pos;
                    m_match = m_match + 1;
                    if (m_match == int'(LockCnt)) m_locked = 1;
                end else begin
                    m_prev    = pos;
                    m_prev_ok = 1;
                    m_match   = 0;
                end
            end
        end
    endfunction

    // One clock: drive on the falling edge, sample 1 time unit after the rising edge.
    task automatic step(input bit rst, input bit v, input logic [W-1:0] ring,
                        input string tag);
        @(negedge Clock);
        Reset            = rst;
        bus.Sample_valid = v;
        bus.Ring_in      = ring;
        @(posedge Clock);
        #1;
        model_step(rst, v, ring);
        check({tag, " model Index_out"},   int'(bus.Index_out),   m_idx);
        check({tag, " model Index_valid"}, int'(bus.Index_valid), int'(m_iv));
        check({tag, " model Locked"},      int'(bus.Locked),      int'(m_locked));
        check({tag, " model Err_pulse"},   int'(bus.Err_pulse),   int'(m_err));
        check({tag, " model Err_count"},   int'(bus.Err_count),   m_cnt);
    endtask

    typedef struct {
        bit           rst;
        bit           v;
        logic [W-1:0] ring;
        int           idx;
        bit           iv;
        bit           lk;
        bit           er;
        int           cnt;
    } vec_t;

    vec_t tbl[$];

    function automatic void add(input bit rst, input bit v, input logic [W-1:0] ring,
                                input int idx, input bit iv, input bit lk, input bit er,
                                input int cnt);
        vec_t e;
        e.rst = rst; e.v = v; e.ring = ring; e.idx = idx;
        e.iv = iv; e.lk = lk; e.er = er; e.cnt = cnt;
        tbl.push_back(e);
    endfunction

    initial begin
        logic [W-1:0] ring;
        int           pos;
        int           r;
        int           pulses;
        bit           rst;
        bit           v;

        model_reset();
        bus.Sample_valid = 1'b0;
        bus.Ring_in      = '0;

        //   rst v  ring     idx iv lk er cnt
        add(1, 0, 4'b0000,  0,  0, 0, 0, 0);
        add(0, 1, 4'b0001,  0,  1, 0, 0, 0);
        add(0, 1, 4'b0010,  1,  1, 0, 0, 0);
        add(0, 1, 4'b0100,  2,  1, 1, 0, 0);  // lock after second rotation
        add(0, 1, 4'b1000,  3,  1, 1, 0, 0);
        add(0, 1, 4'b0001,  0,  1, 1, 0, 0);  // wrap MSB -> bit0
        add(0, 1, 4'b0010,  1,  1, 1, 0, 0);
        add(0, 1, 4'b1000,  3,  1, 0, 1, 1);  // skipped position
        add(0, 1, 4'b0001,  0,  1, 0, 0, 1);
        add(0, 1, 4'b0010,  1,  1, 1, 0, 1);  // relocked
        add(0, 1, 4'b0000,  1,  0, 0, 1, 2);  // zero while locked
        add(0, 1, 4'b0110,  1,  0, 0, 0, 2);  // multi-hot in HUNT: silent
        add(0, 0, 4'b0100,  1,  0, 0, 0, 2);  // no valid: hold
        add(0, 1, 4'b0001,  0,  1, 0, 0, 2);
        add(0, 1, 4'b0010,  1,  1, 0, 0, 2);
        add(0, 1, 4'b0100,  2,  1, 1, 0, 2);
        if (StallEn) add(0, 1, 4'b0100, 2, 1, 1, 0, 2);  // repeat is a stall
        else         add(0, 1, 4'b0100, 2, 1, 0, 1, 3);  // repeat is an error
        add(1, 1, 4'b1000,  0,  0, 0, 0, 0);  // reset beats the sample

        for (int i = 0; i < tbl.size(); i++) begin
            string tag;
            tag = $sformatf("vec%0d", i);
            step(tbl[i].rst, tbl[i].v, tbl[i].ring, tag);
            check({tag, " Index_out"},   int'(bus.Index_out),   tbl[i].idx);
            check({tag, " Index_valid"}, int'(bus.Index_valid), int'(tbl[i].iv));
            check({tag, " Locked"},      int'(bus.Locked),      int'(tbl[i].lk));
            check({tag, " Err_pulse"},   int'(bus.Err_pulse),   int'(tbl[i].er));
            check({tag, " Err_count"},   int'(bus.Err_count),   tbl[i].cnt);
        end

        // Randomized traffic, mostly well-formed rotations with faults mixed in.
        pos = 0;
        for (int n = 0; n < 600; n++) begin
            r    = int'($urandom_range(0, 99));
            rst  = 0;
            v    = 1;
            ring = '0;
            if (r < 55) begin
                pos = (pos + 1) % int'(W);
                ring[pos] = 1'b1;
            end else if (r < 65) begin
                ring[pos] = 1'b1;
            end else if (r < 80) begin
                ring = W'($urandom);
            end else if (r < 97) begin
                v = 0;
                ring = W'($urandom);
            end else begin
                rst = 1;
            end
            step(rst, v, ring, $sformatf("rnd%0d", n));
        end

        // Saturation: lock, then 260 locked errors each followed by a relock.
        step(1, 0, 4'b0000, "sat_rst");
        step(0, 1, 4'b0001, "sat_a");
        step(0, 1, 4'b0010, "sat_b");
        step(0, 1, 4'b0100, "sat_c");
        pulses = 0;
        for (int k = 0; k < 260; k++) begin
            step(0, 1, 4'b0001, "sat_err");
            if (bus.Err_pulse) pulses++;
            step(0, 1, 4'b0010, "sat_r1");
            step(0, 1, 4'b0100, "sat_r2");
        end
        check("sat pulses", pulses, 260);
        check("sat Err_count", int'(bus.Err_count), 255);
        check("sat Locked", int'(bus.Locked), 1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
